// File: rtl/plru_tree_ctrl.sv
// Tree pseudo-LRU replacement controller: one (WAYS-1)-bit tree per set, registered victim lookup.
// Define PLRU_FILL_TOUCH_EN to have every returned victim marked MRU automatically.
`timescale 1ns/1ps
module plru_tree_ctrl #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int SET_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_acc_valid,
  input  logic [SET_W-1:0] i_acc_set,
  input  logic [WAY_W-1:0] i_acc_way,
  input  logic             i_vic_req,
  input  logic [SET_W-1:0] i_vic_set,
  input  logic [WAYS-1:0]  i_vic_way_valid,
  input  logic             i_flush,
  output logic             o_vic_valid,
  output logic [WAY_W-1:0] o_vic_way,
  output logic             o_vic_from_invalid
);

  logic [WAYS-2:0]  r_tree [SETS];
  logic [WAYS-2:0]  w_tree_nxt [SETS];
  logic             r_vic_valid;
  logic [WAY_W-1:0] r_vic_way;
  logic             r_vic_from_invalid;
  logic [WAYS-2:0]  w_vic_tree;
  logic [WAY_W-1:0] w_tree_way;
  logic [WAY_W-1:0] w_inv_way;
  logic             w_any_invalid;
`ifdef PLRU_FILL_TOUCH_EN
  logic [SET_W-1:0] r_vic_set;
`endif

  // Walk root to leaf, pointing every node on the path away from the touched way.
  function automatic logic [WAYS-2:0] touchPath(input logic [WAYS-2:0] t,
                                                input logic [WAY_W-1:0] way);
    int n;
    logic b;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = way[WAY_W-1-l];
      for (int k = 0; k < WAYS-1; k++) begin
        if (k == n) t[k] = ~b;
      end
      n = 2*n + 1 + (b ? 1 : 0);
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] walkTree(input logic [WAYS-2:0] t);
    int n;
    logic b;
    logic [WAY_W-1:0] way;
    n   = 0;
    way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int k = 0; k < WAYS-1; k++) begin
        if (k == n) b = t[k];
      end
      way[WAY_W-1-l] = b;
      n = 2*n + 1 + (b ? 1 : 0);
    end
    return way;
  endfunction

  // Touch first so the explicit access wins any node shared with it.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      w_tree_nxt[s] = r_tree[s];
`ifdef PLRU_FILL_TOUCH_EN
      if (r_vic_valid && (r_vic_set == SET_W'(s)))
        w_tree_nxt[s] = touchPath(w_tree_nxt[s], r_vic_way);
`endif
      if (i_acc_valid && (i_acc_set == SET_W'(s)))
        w_tree_nxt[s] = touchPath(w_tree_nxt[s], i_acc_way);
    end
  end

  always_comb begin
    w_vic_tree    = r_tree[i_vic_set];
    w_tree_way    = walkTree(w_vic_tree);
    w_inv_way     = '0;
    w_any_invalid = 1'b0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!i_vic_way_valid[i]) begin
        w_inv_way     = WAY_W'(i);
        w_any_invalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
    end else if (i_flush) begin
      for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) r_tree[s] <= w_tree_nxt[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vic_valid        <= 1'b0;
      r_vic_way          <= '0;
      r_vic_from_invalid <= 1'b0;
    end else begin
      r_vic_valid <= i_vic_req;
      if (i_vic_req) begin
        r_vic_way          <= w_any_invalid ? w_inv_way : w_tree_way;
        r_vic_from_invalid <= w_any_invalid;
      end
    end
  end

`ifdef PLRU_FILL_TOUCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_vic_set <= '0;
    else if (i_vic_req) r_vic_set <= i_vic_set;
  end
`endif

  assign o_vic_valid        = r_vic_valid;
  assign o_vic_way          = r_vic_way;
  assign o_vic_from_invalid = r_vic_from_invalid;

endmodule

// File: tb/tb_plru_tree_ctrl.sv
// Directed bench for plru_tree_ctrl: a 4-way instance for the main behaviour and an 8-way one for fill-touch.
`timescale 1ns/1ps
module tb_plru_tree_ctrl;

  logic       clk;
  logic       rst_n;
  logic       accValid;
  logic [5:0] accSet;
  logic [1:0] accWay;
  logic       vicReq;
  logic [5:0] vicSet;
  logic [3:0] vicWayValid;
  logic       flush;
  logic       vicValid;
  logic [1:0] vicWay;
  logic       vicFromInvalid;

  logic       vicReq8;
  logic [5:0] vicSet8;
  logic       vicValid8;
  logic [2:0] vicWay8;
  logic       vicFromInvalid8;

  int totalCount;
  int badCount;

  plru_tree_ctrl #(.WAYS(4), .SETS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_acc_valid(accValid), .i_acc_set(accSet), .i_acc_way(accWay),
    .i_vic_req(vicReq), .i_vic_set(vicSet), .i_vic_way_valid(vicWayValid),
    .i_flush(flush),
    .o_vic_valid(vicValid), .o_vic_way(vicWay), .o_vic_from_invalid(vicFromInvalid)
  );

  plru_tree_ctrl #(.WAYS(8), .SETS(64)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .i_acc_valid(1'b0), .i_acc_set(6'd0), .i_acc_way(3'd0),
    .i_vic_req(vicReq8), .i_vic_set(vicSet8), .i_vic_way_valid(8'hFF),
    .i_flush(1'b0),
    .o_vic_valid(vicValid8), .o_vic_way(vicWay8), .o_vic_from_invalid(vicFromInvalid8)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input int aSet, input int aWay,
                               input logic vr, input int vSet, input logic [3:0] vValid,
                               input logic fl);
    accValid    = av;
    accSet      = 6'(aSet);
    accWay      = 2'(aWay);
    vicReq      = vr;
    vicSet      = 6'(vSet);
    vicWayValid = vValid;
    flush       = fl;
    tick();
    accValid = 1'b0;
    vicReq   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic doAccess(input int aSet, input int aWay);
    applyStimulus(1'b1, aSet, aWay, 1'b0, 0, 4'hF, 1'b0);
  endtask

  task automatic doVictim(input string tag, input int vSet, input logic [3:0] vValid,
                          input int expWay, input int expInv);
    applyStimulus(1'b0, 0, 0, 1'b1, vSet, vValid, 1'b0);
    checkOutput({tag, ".valid"}, int'(vicValid), 1);
    checkOutput({tag, ".way"}, int'(vicWay), expWay);
    checkOutput({tag, ".inv"}, int'(vicFromInvalid), expInv);
  endtask

  task automatic doVictim8(input string tag, input int expWay);
    vicReq8 = 1'b1;
    vicSet8 = 6'd3;
    tick();
    vicReq8 = 1'b0;
    checkOutput({tag, ".valid"}, int'(vicValid8), 1);
    checkOutput({tag, ".way"}, int'(vicWay8), expWay);
    tick();
  endtask

  initial begin
    totalCount  = 0;
    badCount    = 0;
    rst_n       = 1'b0;
    accValid    = 1'b0;
    accSet      = '0;
    accWay      = '0;
    vicReq      = 1'b0;
    vicSet      = '0;
    vicWayValid = 4'hF;
    flush       = 1'b0;
    vicReq8     = 1'b0;
    vicSet8     = '0;
    #12;
    checkOutput("reset.valid", int'(vicValid), 0);
    checkOutput("reset.way", int'(vicWay), 0);
    checkOutput("reset.inv", int'(vicFromInvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    doVictim("rst_set0", 0, 4'hF, 0, 0);
    tick();
    checkOutput("idle.valid", int'(vicValid), 0);

    doAccess(5, 0);
    doAccess(5, 1);
    doVictim("set5a", 5, 4'hF, 2, 0);
    doAccess(5, 3);
    doAccess(5, 2);
    doVictim("set5b", 5, 4'hF, 0, 0);

    doVictim("set9inv", 9, 4'b1011, 2, 1);
    tick();
    checkOutput("hold.valid", int'(vicValid), 0);
    checkOutput("hold.way", int'(vicWay), 2);
    checkOutput("hold.inv", int'(vicFromInvalid), 1);
    doVictim("set9tree", 9, 4'hF, 0, 0);
    doVictim("set9inv3", 9, 4'b0111, 3, 1);

    // Access and victim on set 7 in one cycle: result must predate the access.
    applyStimulus(1'b1, 7, 0, 1'b1, 7, 4'hF, 1'b0);
    checkOutput("same.valid", int'(vicValid), 1);
    checkOutput("same.way", int'(vicWay), 0);
    doVictim("after", 7, 4'hF, 2, 0);

    doAccess(1, 0);
    doAccess(2, 1);
    doVictim("pre1", 1, 4'hF, 2, 0);
    // Victim in the flush cycle still sees the old tree.
    applyStimulus(1'b0, 0, 0, 1'b1, 1, 4'hF, 1'b1);
    checkOutput("flushcyc.way", int'(vicWay), 2);
    doVictim("flush1", 1, 4'hF, 0, 0);
    doVictim("flush2", 2, 4'hF, 0, 0);

    doAccess(12, 0);
    vicReq      = 1'b1;
    vicSet      = 6'd12;
    vicWayValid = 4'hF;
    tick();
    checkOutput("burst.way", int'(vicWay), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.valid", int'(vicValid), 0);
    checkOutput("midrst.way", int'(vicWay), 0);
    vicReq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("postrst.valid", int'(vicValid), 0);
    doVictim("postrst12", 12, 4'hF, 0, 0);

`ifdef PLRU_FILL_TOUCH_EN
    doVictim8("touch0", 0);
    doVictim8("touch1", 4);
    doVictim8("touch2", 2);
    doVictim8("touch3", 6);
`else
    doVictim8("touch0", 0);
    doVictim8("touch1", 0);
    doVictim8("touch2", 0);
    doVictim8("touch3", 0);
`endif

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/plru_tree_ctrl.md
# plru_tree_ctrl

Stateful tree pseudo-LRU replacement controller for an N-way set-associative cache.
- Holds one (WAYS-1)-bit PLRU tree per set.
- Updates the tree on every access, and returns a registered victim way on request.
- Prefers invalid ways over the tree choice.
- Sits beside the cache tag array: the cache controller drives accesses on hit/fill and requests a victim on miss.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- SETS, 64, number of sets; power of two, ≥2
- SET_W, $clog2(SETS), set index width (derived)
- WAY_W, $clog2(WAYS), way index width (derived)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- acc_valid  input  1  access (hit or fill) occurred this cycle
- acc_set  input  SET_W  set of the access
- acc_way  input  WAY_W  way accessed
- vic_req  input  1  victim lookup request
- vic_set  input  SET_W  set to choose a victim in
- vic_way_valid  input  WAYS  valid bit per way of vic_set, sampled with vic_req
- vic_valid  output  1  victim result valid, one-cycle pulse
- vic_way  output  WAY_W  chosen victim way
- vic_from_invalid  output  1  victim came from the invalid-way path
- flush  input  1  synchronous clear of all tree state

## Operation
- Tree layout per set: heap-ordered nodes 0..WAYS-2, node 0 = root; children of node n are 2n+1 (left) and 2n+2 (right). Leaf way w corresponds to heap position w+WAYS-1.
- Node bit semantics: 0 = LRU side is left subtree, 1 = LRU side is right subtree.
- Access update (acc_valid=1): walk the path from root to acc_way.
  - Each node on the path is set to point away from the way: the bit becomes 1 if the path went left, 0 if it went right.
  - Nodes off the path are unchanged.
- Victim selection (vic_req=1):
  - If any bit of vic_way_valid is 0, vic_way is the lowest-indexed invalid way and vic_from_invalid=1.
  - Otherwise, walk from the root following the bits (0→left, 1→right); the reached leaf is vic_way and vic_from_invalid=0.
- Victim read uses the tree state registered at the start of the vic_req cycle. An access in the same cycle to the same set is not visible in that result.
- flush=1 clears every tree to all zeros at the next edge. Flush has priority over access and fill-touch updates in the same cycle. A victim computed in the flush cycle still uses the pre-flush state.
- acc_way and vic_set values outside range cannot occur, because widths are exact powers of two.

## Timing
- Reset (rst_n=0, asynchronous): all tree bits=0, vic_valid=0, vic_way=0, vic_from_invalid=0.
- Reset deassertion mid-operation: any pending vic_req result is discarded; vic_valid stays 0 until a new vic_req.
- Access update: visible to any vic_req issued in the cycle after acc_valid.
- Victim latency: vic_req in cycle t → vic_valid=1 with vic_way and vic_from_invalid in cycle t+1.
  - vic_valid is 0 in any cycle not following a vic_req.
  - Back-to-back vic_req is allowed, one result per cycle.
- vic_way and vic_from_invalid hold their last values while vic_valid=0.
- No backpressure: the requester must capture the result in the vic_valid cycle.

## Configuration
- PLRU_FILL_TOUCH_EN defined:
  - The victim returned in cycle t+1 is automatically applied as an access to vic_set at the t+1 edge, so the tree marks it MRU without a separate acc_valid.
  - If acc_valid in cycle t+1 targets the same set, both paths are applied, and acc_way wins on any shared node.
  - flush in cycle t+1 suppresses the touch.
- PLRU_FILL_TOUCH_EN undefined: tree state changes only on acc_valid and flush; vic_req never modifies state.

## Test plan
- WAYS=4: reset, vic_req set 0 with valid=4'b1111 → next cycle vic_valid=1, vic_way=0, vic_from_invalid=0.
- Access set 5 way 0, then way 1, then vic_req set 5 all valid → vic_way=2. Then access 3, 2, vic_req → vic_way=0.
- vic_req set 9 with valid=4'b1011 → vic_way=2, vic_from_invalid=1, tree unchanged.
- acc_valid and vic_req on the same set in the same cycle → victim reflects pre-access state; a vic_req the next cycle reflects the update.
- Accesses to sets 1 and 2, then flush, then vic_req on each set with all valid → vic_way=0. Assert rst_n=0 mid-burst → outputs 0 immediately.
- With PLRU_FILL_TOUCH_EN, WAYS=8: four consecutive vic_req to set 3, all valid → ways 0, 4, 2, 6. Without the macro → 0, 0, 0, 0.
